ex_stage: RTL

Execute stage sitting directly downstream of the ID/EX pipeline register; consumes the decoded operand/control bundle and produces the registered EX/MEM bundle.
- Single-cycle ALU for all ops except MUL.
- MUL uses an iterative shift-add multiplier; the stage asserts stall_o so the ID/EX register and earlier stages hold while the product is computed.
- flush squashes the in-flight instruction for branch redirects.

---
 rtl/ex_stage.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage, single-cycle ALU plus optional iterative MUL.
// Define EX_MUL_EN to build the shift-add multiplier and its BUSY state.
module ex_stage #(
   parameter int XLEN = 16,
   parameter int RA_W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_use_imm,
   input  logic [RA_W-1:0] in_rd,
   input  logic            in_reg_write,
   input  logic            in_mem_read,
   input  logic            in_mem_write,
   input  logic            flush,
   output logic            stall_o,
   output logic            out_valid,
   output logic [XLEN-1:0] out_result,
   output logic [XLEN-1:0] out_store_data,
   output logic [RA_W-1:0] out_rd,
   output logic            out_reg_write,
   output logic            out_mem_read,
   output logic            out_mem_write
);
   localparam int SW = $clog2(XLEN);
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLL = 4'd5;
   localparam logic [3:0] OP_SRL = 4'd6;
   localparam logic [3:0] OP_SLT = 4'd7;
   localparam logic [3:0] OP_PB  = 4'd9;

   typedef struct packed {
      logic [XLEN-1:0] sd;
      logic [RA_W-1:0] rd;
      logic            rw;
      logic            mr;
      logic            mw;
   } ctl_t;

   ctl_t            in_ctl;
   ctl_t            ctl_q;
   ctl_t            ctl_d;
   logic            valid_q;
   logic            valid_d;
   logic [XLEN-1:0] res_q;
   logic [XLEN-1:0] res_d;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_res;
   logic            slt;

   assign in_ctl = {in_rs2, in_rd, in_reg_write,
                    in_mem_read, in_mem_write};

   // Single-cycle ALU; MUL and reserved ops yield 0 here
   always_comb begin
      op_b    = in_use_imm ? in_imm : in_rs2;
      slt     = $signed(in_a) < $signed(op_b);
      alu_res = '0;
      unique case (in_op)
         OP_ADD:  alu_res = in_a + op_b;
         OP_SUB:  alu_res = in_a - op_b;
         OP_AND:  alu_res = in_a & op_b;
         OP_OR:   alu_res = in_a | op_b;
         OP_XOR:  alu_res = in_a ^ op_b;
         OP_SLL:  alu_res = in_a << op_b[SW-1:0];
         OP_SRL:  alu_res = in_a >> op_b[SW-1:0];
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, slt};
         OP_PB:   alu_res = op_b;
         default: alu_res = '0;
      endcase
   end

   // EX/MEM output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         res_q   <= '0;
         ctl_q   <= '0;
      end else begin
         valid_q <= valid_d;
         res_q   <= res_d;
         ctl_q   <= ctl_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_result     = res_q;
   assign out_store_data = ctl_q.sd;
   assign out_rd         = ctl_q.rd;
   assign out_reg_write  = ctl_q.rw;
   assign out_mem_read   = ctl_q.mr;
   assign out_mem_write  = ctl_q.mw;

`ifdef EX_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q;
   state_t          state_d;
   logic [SW-1:0]   cnt_q;
   logic [SW-1:0]   cnt_d;
   logic [XLEN-1:0] mcand_q;
   logic [XLEN-1:0] mcand_d;
   logic [XLEN-1:0] mplier_q;
   logic [XLEN-1:0] mplier_d;
   logic [XLEN-1:0] acc_q;
   logic [XLEN-1:0] acc_d;
   logic [XLEN-1:0] step_sum;
   ctl_t            lat_q;
   ctl_t            lat_d;
   logic            stall_c;

   // Multiplier FSM state and operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         lat_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         lat_q    <= lat_d;
      end
   end

   // Next state: flush, then BUSY step, then MUL accept, then ALU op
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      lat_d     = lat_q;
      valid_d   = 1'b0;
      res_d     = res_q;
      ctl_d     = ctl_q;
      ctl_d.rw  = 1'b0;
      ctl_d.mr  = 1'b0;
      ctl_d.mw  = 1'b0;
      stall_c   = 1'b0;
      step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == BUSY) begin
         acc_d    = step_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (&cnt_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b1;
            res_d   = step_sum;
            ctl_d   = lat_q;
         end else begin
            stall_c = 1'b1;
         end
      end else if (in_valid && in_op == OP_MUL) begin
         stall_c  = 1'b1;
         state_d  = BUSY;
         cnt_d    = '0;
         acc_d    = '0;
         mcand_d  = in_a;
         mplier_d = op_b;
         lat_d    = in_ctl;
      end else if (in_valid) begin
         valid_d = 1'b1;
         res_d   = alu_res;
         ctl_d   = in_ctl;
      end
   end

   assign stall_o = stall_c & rst_n;
`else
   // Single-cycle only: op 8 lands in the reserved arm of the ALU
   always_comb begin
      valid_d  = 1'b0;
      res_d    = res_q;
      ctl_d    = ctl_q;
      ctl_d.rw = 1'b0;
      ctl_d.mr = 1'b0;
      ctl_d.mw = 1'b0;
      if (in_valid && !flush) begin
         valid_d = 1'b1;
         res_d   = alu_res;
         ctl_d   = in_ctl;
      end
   end

   assign stall_o = 1'b0;
`endif
endmodule
